if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and decode. Fetch pushes 32-bit instruction words with their PC through a valid/ready handshake. The block buffers up to DEPTH entries in order and presents the oldest entry to decode, together with pre-extracted RV32 register and opcode fields. A synchronous flush discards all buffered instructions on a redirect, such as a taken branch or jump.

## Interface
Parameters:
- DEPTH, 4, entries; power of two, ≥2
- IW, 32, instruction width; fixed at 32 for field extraction
- AW, 32, PC width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals !full
- in_instr  in  IW  instruction word
- in_pc  in  AW  PC of in_instr
- flush  in  1  synchronous discard of all entries
- out_valid  out  1  head entry available
- out_ready  in  1  decode consumes head
- out_instr  out  IW  head instruction; 0 when !out_valid
- out_pc  out  AW  head PC; 0 when !out_valid
- out_opcode  out  7  out_instr[6:0]
- out_rd  out  5  out_instr[11:7]
- out_rs1  out  5  out_instr[19:15]
- out_rs2  out  5  out_instr[24:20]
- out_illegal  out  1  opcode check result (see Configuration)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer of DEPTH {pc, instr} entries, with write pointer, read pointer, and count registers.
- Push: occurs when in_valid && in_ready && !flush. The entry is written at wptr, and wptr increments, wrapping modulo DEPTH.
- Pop: occurs when out_valid && out_ready && !flush. rptr increments, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Output path:
  - The queue is first-word-fall-through.
  - out_valid = (count != 0).
  - Head fields are read combinationally from mem[rptr].
  - When !out_valid, all head fields are masked to 0.
- in_ready = (count != DEPTH). It does not consider a same-cycle pop, so a full queue stalls fetch for one cycle even if decode pops.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Sets wptr, rptr, and count to 0. The instruction presented that cycle is dropped.
  - Memory contents are not cleared.
- Input stability: fetch must hold in_instr/in_pc stable while in_valid && !in_ready. The block does not check this.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - count = 0, pointers = 0.
  - in_ready = 1, out_valid = 0.
  - out_instr, out_pc, all fields, and out_illegal = 0.
- Latency: an instruction pushed at edge N is visible at the outputs after edge N, for consumption at edge N+1. Minimum latency is 1 cycle with no bypass.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Empty with push: no pop that cycle, because out_valid = 0. out_valid rises after the edge.
- Full with pop: the pop completes and in_ready rises after the edge.
- Pointer wrap: after DEPTH pushes, wptr returns to 0. Ordering is preserved across the wrap.
- Reset asserted mid-operation: all entries are lost immediately. The first push after rst_n deasserts lands at entry 0.
- Flush and rst_n produce identical visible state. Flush takes effect at the next edge.

## Configuration
- IQ_ILLEGAL_CHECK_EN defined:
  - out_illegal = out_valid && (out_instr[1:0] != 2'b11 || opcode ∉ {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011}).
  - The entry is still delivered normally. Decode decides whether to trap.
- IQ_ILLEGAL_CHECK_EN undefined: out_illegal is tied to 0 and no check logic is synthesised.

## Test plan
- Reset then idle → in_ready=1, out_valid=0, count=0, out_instr=0.
- Push 0x00500093 @ PC 0x0 with out_ready=0 → next cycle:
  - out_valid=1, out_instr=0x00500093, out_pc=0x0.
  - out_opcode=0x13, out_rd=1, out_rs1=0.
  - count=1.
- Push 4 words (PC 0x0,0x4,0x8,0xC) with out_ready=0 → count=4 and in_ready=0. A fifth in_valid is not accepted. Draining with out_ready=1 yields PCs 0x0,0x4,0x8,0xC in order.
- Sustain in_valid=1 and out_ready=1 for 10 cycles starting at count=2 → count stays 2. No instruction is lost or duplicated across the pointer wrap.
- Fill with 3 entries, then assert flush together with in_valid → next cycle count=0, out_valid=0, and the flushed-cycle instruction is absent.
- With IQ_ILLEGAL_CHECK_EN defined, push 0xFFFFFFFF → out_illegal=1. Push 0x00000013 → out_illegal=0. With the macro undefined, out_illegal=0 for both.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction buffer between fetch and decode.
// First-word-fall-through circular buffer of DEPTH {pc, instr} entries. The
// head entry is presented with its RV32 opcode/rd/rs1/rs2 fields pre-extracted.
// A synchronous flush drops everything buffered, plus any word offered that cycle.
// Optional feature macro: IQ_ILLEGAL_CHECK_EN enables the opcode legality
// flag on out_illegal. When the macro is absent, out_illegal is tied low.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [6:0]    out_opcode,
  output logic [4:0]    out_rd,
  output logic [4:0]    out_rs1,
  output logic [4:0]    out_rs2,
  output logic          out_illegal,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          push, pop;
  entry_t        head;

  // A full queue ignores a same-cycle pop, so fetch stalls for one cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Storage is never cleared. Stale entries are hidden by count and the output mask.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{pc: in_pc, instr: in_instr};
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields fall through combinationally and are masked to zero when the queue is empty.
  always_comb begin
    head      = mem[rptr];
    out_instr = out_valid ? head.instr : '0;
    out_pc    = out_valid ? head.pc    : '0;
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];

`ifdef IQ_ILLEGAL_CHECK_EN
  logic op_known;

  // Flags words outside the supported RV32I major opcodes. Decode decides whether to trap.
  always_comb begin
    op_known = 1'b0;
    case (out_opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
        op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
    out_illegal = out_valid && (out_instr[1:0] != 2'b11 || !op_known);
  end
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a table of cycles driven through a reference queue
// scoreboard, plus hand-written reset, first-push and async-reset sequences.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [31:0]   in_instr = '0, in_pc = '0;
  logic          flush = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [31:0]   out_instr, out_pc;
  logic [6:0]    out_opcode;
  logic [4:0]    out_rd, out_rs1, out_rs2;
  logic          out_illegal;
  logic [CW-1:0] count;

  if_id_queue #(.DEPTH(DEPTH), .IW(32), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int          exp_cnt;
  } vec_t;

  ent_t q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef IQ_ILLEGAL_CHECK_EN
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73:
        return 1'b0;
      default: return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  function automatic void add(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                              input logic ordy, input logic fl, input int cnt);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy; v.fl = fl; v.exp_cnt = cnt;
    tbl.push_back(v);
  endfunction

  // Compare the visible state against the scoreboard head and occupancy.
  task automatic check_outputs();
    logic [31:0] w;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    w = (q.size() != 0) ? q[0].instr : 32'h0;
    chk("out_instr", 64'(out_instr), 64'(w));
    chk("out_pc", 64'(out_pc), 64'((q.size() != 0) ? q[0].pc : 32'h0));
    chk("out_opcode", 64'(out_opcode), 64'(w[6:0]));
    chk("out_rd", 64'(out_rd), 64'(w[11:7]));
    chk("out_rs1", 64'(out_rs1), 64'(w[19:15]));
    chk("out_rs2", 64'(out_rs2), 64'(w[24:20]));
    chk("out_illegal", 64'(out_illegal), 64'((q.size() != 0) && exp_illegal(w)));
  endtask

  // One cycle: drive, check pre-edge outputs, advance the model, check count after the edge.
  task automatic step(input vec_t v);
    int sz;
    @(negedge clk);
    in_valid = v.iv; in_instr = v.instr; in_pc = v.pc; out_ready = v.ordy; flush = v.fl;
    #1;
    check_outputs();
    sz = q.size();
    if (v.fl) q.delete();
    else begin
      if (v.ordy && sz > 0) void'(q.pop_front());
      if (v.iv && sz < DEPTH) q.push_back('{instr: v.instr, pc: v.pc});
    end
    @(posedge clk);
    #1;
    chk("count_after_edge", 64'(count), 64'(v.exp_cnt));
  endtask

  initial begin
    vec_t v;
    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First push with explicit field constants.
    v = '{iv: 1'b1, instr: 32'h00500093, pc: 32'h0, ordy: 1'b0, fl: 1'b0, exp_cnt: 1};
    step(v);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_instr", 64'(out_instr), 64'h00500093);
    chk("first_opcode", 64'(out_opcode), 64'h13);
    chk("first_rd", 64'(out_rd), 64'd1);
    chk("first_rs1", 64'(out_rs1), 64'd0);
    v = '{iv: 1'b0, instr: 32'h0, pc: 32'h0, ordy: 1'b1, fl: 1'b0, exp_cnt: 0};
    step(v);

    // Fill to full, then drop a fifth word. Pop while full, then drain.
    for (int i = 0; i < 4; i++) add(1, 32'h00000013 | (i << 7), 32'(i * 4), 0, 0, i + 1);
    add(1, 32'h00A00113, 32'h10, 0, 0, 4);
    add(1, 32'h00B00113, 32'h14, 1, 0, 3);
    for (int i = 0; i < 3; i++) add(0, 32'h0, 32'h0, 1, 0, 2 - i);
    // Push into an empty queue with out_ready high: nothing can pop that cycle.
    add(1, 32'h00100193, 32'h20, 1, 0, 1);
    add(1, 32'h00200193, 32'h24, 0, 0, 2);
    // Sustained push and pop across the pointer wrap.
    for (int i = 0; i < 10; i++) add(1, 32'h00300213 + (i << 20), 32'h28 + 32'(i * 4), 1, 0, 2);
    // A flush with in_valid drops both the buffer and the offered word.
    add(1, 32'h00400293, 32'h50, 0, 0, 3);
    add(1, 32'h00500313, 32'h54, 0, 1, 0);
    add(0, 32'h0, 32'h0, 1, 0, 0);
    // Opcode legality flag.
    add(1, 32'hFFFFFFFF, 32'h60, 0, 0, 1);
    add(1, 32'h00000013, 32'h64, 1, 0, 1);
    add(0, 32'h0, 32'h0, 1, 0, 0);
    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset mid-operation loses everything at once.
    v = '{iv: 1'b1, instr: 32'h00700393, pc: 32'h70, ordy: 1'b0, fl: 1'b0, exp_cnt: 1};
    step(v);
    v = '{iv: 1'b1, instr: 32'h00800413, pc: 32'h74, ordy: 1'b0, fl: 1'b0, exp_cnt: 2};
    step(v);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{iv: 1'b1, instr: 32'h00900493, pc: 32'h80, ordy: 1'b0, fl: 1'b0, exp_cnt: 1};
    step(v);
    v = '{iv: 1'b0, instr: 32'h0, pc: 32'h0, ordy: 1'b1, fl: 1'b0, exp_cnt: 0};
    step(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
